// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared phase encoding, coordinate width and 640x480@60 defaults
package vga_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int MAX_TOTAL = 4096;

  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FRONT  = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BACK   = 2'd3;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one display axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [11:0] pos_o,
  output logic [1:0]  phase_o,
  output logic        wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL > MAX_TOTAL) begin : g_bad_cfg
    $error("vga_axis_timer: every segment must be >= 1 and the total <= 4096");
  end

  localparam logic [11:0] END_ACTIVE = 12'(ACTIVE - 1);
  localparam logic [11:0] END_FRONT  = 12'(ACTIVE + FP - 1);
  localparam logic [11:0] END_SYNC   = 12'(ACTIVE + FP + SYNC - 1);
  localparam logic [11:0] END_TOTAL  = 12'(TOTAL - 1);

  logic [11:0] pos_q, pos_d;
  logic [1:0]  phase_q, phase_d;

  assign wrap_o  = (pos_q == END_TOTAL);
  assign pos_o   = pos_q;
  assign phase_o = phase_q;

  // Each phase only ever checks its own end point, so one-long segments still step correctly.
  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (adv_i) begin
      pos_d = wrap_o ? 12'd0 : pos_q + 12'd1;
      case (phase_q)
        PH_ACTIVE: if (pos_q == END_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (pos_q == END_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (pos_q == END_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (pos_q == END_TOTAL)  phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      pos_q   <= 12'd0;
      phase_q <= PH_ACTIVE;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing top: axis timers, vertical gating, registered decode stage
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  logic [11:0] hpos, vpos;
  logic [1:0]  hphase, vphase;
  logic        h_wrap, v_wrap_unused;

  vga_axis_timer #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_timer (
    .pix_clk (pix_clk),
    .rst     (rst),
    .adv_i   (en),
    .pos_o   (hpos),
    .phase_o (hphase),
    .wrap_o  (h_wrap)
  );

  // Vertical axis steps once per line, on the same edge the horizontal counter wraps.
  vga_axis_timer #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_timer (
    .pix_clk (pix_clk),
    .rst     (rst),
    .adv_i   (en && h_wrap),
    .pos_o   (vpos),
    .phase_o (vphase),
    .wrap_o  (v_wrap_unused)
  );

  logic        hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic [11:0] x_q, y_q;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (en) begin
        x_q           <= hpos;
        y_q           <= vpos;
        video_on_q    <= (hphase == PH_ACTIVE) && (vphase == PH_ACTIVE);
        hsync_q       <= (hphase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= (vphase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        line_start_q  <= (hpos == 12'd0);
        frame_start_q <= (hpos == 12'd0) && (vpos == 12'd0);
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
